timer_arbiter: RTL and testbench

- Round-robin scheduler that shares a single modulo tick counter among N_REQ requesters.
- Each requester asks for a delay of D ticks. The arbiter grants one requester, counts D enabled ticks on the shared counter, then pulses that requester's done line.
- Sits between the tick source (prescaler ENA strobe) and the client FSMs that need timed waits, replacing one free-running counter per client.

---
 rtl/timer_arbiter.sv | 115 +++++++++++
 tb/tb_timer_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared tick counter to N_REQ requesters in turn.
// Optional build macro TIMER_ARB_ABORT_EN: dropping REQ of the granted requester abandons its run.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     TICK,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ*WIDTH-1:0]   DELAY,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         DONE,
  output logic                     BUSY,
  output logic [WIDTH-1:0]         count
);

  localparam int LW = $clog2(N_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] target_reg;
  logic [LW-1:0]    win_reg;
  logic [LW-1:0]    last_reg;

  logic [WIDTH-1:0] delay_arr [N_REQ];
  logic             win_valid;
  logic [LW-1:0]    win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_delay
      assign delay_arr[gi] = DELAY[gi*WIDTH +: WIDTH];
    end
  endgenerate

  function automatic logic [LW-1:0] rr_idx(input logic [LW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_REQ;
    return LW'(s);
  endfunction

  // Scan from farthest to nearest so the candidate closest after last wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (REQ[rr_idx(last_reg, k)]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx(last_reg, k);
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      count_reg  <= '0;
      target_reg <= '0;
      win_reg    <= '0;
      last_reg   <= LW'(N_REQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            target_reg <= delay_arr[win_idx];
            gnt_reg    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            win_reg    <= win_idx;
            count_reg  <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
`ifdef TIMER_ARB_ABORT_EN
          if (!REQ[win_reg]) begin
            gnt_reg   <= '0;
            count_reg <= '0;
            last_reg  <= win_reg;
            state_reg <= IDLE;
          end else
`endif
          if (target_reg == '0) begin
            state_reg <= FIN;
          end else if (TICK) begin
            // target-1 is only formed here, where target is known non-zero
            if (count_reg == target_reg - 1'b1) begin
              count_reg <= '0;
              state_reg <= FIN;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        FIN: begin
          gnt_reg   <= '0;
          last_reg  <= win_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign GNT   = gnt_reg;
  assign DONE  = (state_reg == FIN) ? gnt_reg : '0;
  assign BUSY  = (state_reg != IDLE);
  assign count = count_reg;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: reset, single run, round-robin, zero/sparse/max delay, abort.
module tb_timer_arbiter;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        TICK  = 1'b0;
  logic [3:0]  REQ   = '0;
  logic [31:0] DELAY = '0;
  logic [3:0]  GNT;
  logic [3:0]  DONE;
  logic        BUSY;
  logic [7:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  timer_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .REQ(REQ), .DELAY(DELAY),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .count(count)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_delay(input int i, input logic [7:0] v);
    DELAY[i*8 +: 8] = v;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int got;
    // reset state
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    chk("rst_gnt", GNT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_count", count, 0);

    // single request, delay 5, tick every cycle
    REQ = 4'b0010; set_delay(1, 8'd5); TICK = 1'b1;
    step();
    chk("single_gnt", GNT, 4'b0010);
    chk("single_busy", BUSY, 1);
    chk("single_c0", count, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("single_c%0d", i), count, i);
      chk($sformatf("single_nodone%0d", i), DONE, 0);
    end
    step();
    chk("single_done", DONE, 4'b0010);
    chk("single_fin_gnt", GNT, 4'b0010);
    chk("single_fin_count", count, 0);
    REQ = 4'b0000;
    step();
    chk("single_idle_gnt", GNT, 0);
    chk("single_idle_done", DONE, 0);
    chk("single_idle_busy", BUSY, 0);

    // asynchronous reset in the middle of a run
    REQ = 4'b0001; set_delay(0, 8'd10);
    step();
    chk("mid_gnt", GNT, 4'b0001);
    step(); step(); step();
    chk("mid_c3", count, 3);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_gnt", GNT, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_count", count, 0);
    #1 RESET = 1'b0;
    @(negedge CLOCK);
    chk("mid_regrant", GNT, 4'b0001);
    REQ = 4'b0000;
    RESET = 1'b1;
    #1 RESET = 1'b0;
    @(negedge CLOCK);
    chk("mid_rst2_gnt", GNT, 0);

    // round-robin with all requesting
    for (int i = 0; i < 4; i++) set_delay(i, 8'd2);
    REQ = 4'b1111; TICK = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      step();
      if (DONE != 4'b0000) begin
        chk($sformatf("rr_done%0d", got), DONE, rr_exp[got]);
        got++;
      end
    end
    chk("rr_ndone", got, 5);
    REQ = 4'b0000;
    step();
    chk("rr_idle_gnt", GNT, 0);

    // zero delay, no ticks
    REQ = 4'b0100; set_delay(2, 8'd0); TICK = 1'b0;
    step();
    chk("zero_gnt", GNT, 4'b0100);
    chk("zero_nodone", DONE, 0);
    step();
    chk("zero_done", DONE, 4'b0100);
    chk("zero_fin_busy", BUSY, 1);
    REQ = 4'b0000;
    step();
    chk("zero_idle_gnt", GNT, 0);
    chk("zero_idle_busy", BUSY, 0);

    // delay 3 with a tick every fourth cycle
    REQ = 4'b0001; set_delay(0, 8'd3);
    step();
    chk("sparse_gnt", GNT, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      TICK = ((i % 4) == 3);
      step();
      if (i < 11) begin
        chk($sformatf("sparse_c%0d", i), count, (i + 1) / 4);
        chk($sformatf("sparse_nodone%0d", i), DONE, 0);
      end else begin
        chk("sparse_done", DONE, 4'b0001);
        chk("sparse_fin_count", count, 0);
      end
    end
    TICK = 1'b0; REQ = 4'b0000;
    step();
    chk("sparse_idle_gnt", GNT, 0);

    // maximum delay
    REQ = 4'b0010; set_delay(1, 8'd255); TICK = 1'b1;
    step();
    chk("max_gnt", GNT, 4'b0010);
    chk("max_c0", count, 0);
    for (int i = 1; i <= 254; i++) begin
      step();
      if (i == 128 || i == 254) chk($sformatf("max_c%0d", i), count, i);
    end
    chk("max_nodone", DONE, 0);
    step();
    chk("max_done", DONE, 4'b0010);
    chk("max_fin_count", count, 0);
    REQ = 4'b0000;
    step();
    chk("max_idle_gnt", GNT, 0);

    // drop REQ[3] at count 2 with REQ[0] pending
    set_delay(3, 8'd5); set_delay(0, 8'd1);
    REQ = 4'b1001; TICK = 1'b1;
    step();
    chk("abort_gnt", GNT, 4'b1000);
    step(); step();
    chk("abort_c2", count, 2);
    REQ = 4'b0001;
    step();
`ifdef TIMER_ARB_ABORT_EN
    chk("abort_gnt0", GNT, 0);
    chk("abort_nodone", DONE, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_count", count, 0);
    step();
    chk("abort_next_gnt", GNT, 4'b0001);
`else
    chk("noabort_c3", count, 3);
    chk("noabort_gnt", GNT, 4'b1000);
    step();
    chk("noabort_c4", count, 4);
    step();
    chk("noabort_done", DONE, 4'b1000);
    step();
    chk("noabort_idle_gnt", GNT, 0);
    step();
    chk("noabort_next_gnt", GNT, 4'b0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
